// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, blank/sync decode, and syncs delayed
// to line up with renderer RGB that lands PIPE_DELAY cycles after DrawX/DrawY.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       hs_d,
    output logic       vs_d,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [9:0]            hc_reg;
    logic [9:0]            vc_reg;
    logic                  running_reg;
    logic [7:0]            frame_count_reg;
    logic [PIPE_DELAY-1:0] hs_pipe_reg;
    logic [PIPE_DELAY-1:0] vs_pipe_reg;

    // The first cycle out of reset only arms running, so (0,0) is shown for a full cycle.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hc_reg          <= '0;
            vc_reg          <= '0;
            running_reg     <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            running_reg <= 1'b1;
            if (running_reg) begin
                if (hc_reg == H_LAST) begin
                    hc_reg <= '0;
                    if (vc_reg == V_LAST) begin
                        vc_reg          <= '0;
                        frame_count_reg <= frame_count_reg + 8'd1;
                    end else begin
                        vc_reg <= vc_reg + 10'd1;
                    end
                end else begin
                    hc_reg <= hc_reg + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hs_pipe_reg <= '1;
            vs_pipe_reg <= '1;
        end else begin
            hs_pipe_reg[0] <= hs;
            vs_pipe_reg[0] <= vs;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                hs_pipe_reg[i] <= hs_pipe_reg[i-1];
                vs_pipe_reg[i] <= vs_pipe_reg[i-1];
            end
        end
    end

    assign DrawX       = hc_reg;
    assign DrawY       = vc_reg;
    assign blank       = running_reg & (hc_reg < H_VIS) & (vc_reg < V_VIS);
    assign hs          = ~(running_reg & (hc_reg >= HS_START) & (hc_reg <= HS_END));
    assign vs          = ~(running_reg & (vc_reg >= VS_START) & (vc_reg <= VS_END));
    assign frame_start = running_reg & (hc_reg == 10'd0) & (vc_reg == 10'd0);
    assign frame_count = frame_count_reg;
    assign hs_d        = hs_pipe_reg[PIPE_DELAY-1];
    assign vs_d        = vs_pipe_reg[PIPE_DELAY-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full 640x480 timing for reset/line/lag-2 checks, and a
// shrunken 16x11 raster (PIPE_DELAY=3) so frame, mid-frame reset and 256-frame wrap fit.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic [9:0] a_x, a_y, b_x, b_y;
    logic       a_blank, a_hs, a_vs, a_hs_d, a_vs_d, a_fs;
    logic       b_blank, b_hs, b_vs, b_hs_d, b_vs_d, b_fs;
    logic [7:0] a_fc, b_fc;

    int tests_run    = 0;
    int tests_failed = 0;

    vga_timing_gen dut_a (
        .vga_clk(clk), .reset_n(rst_a), .DrawX(a_x), .DrawY(a_y), .blank(a_blank),
        .hs(a_hs), .vs(a_vs), .hs_d(a_hs_d), .vs_d(a_vs_d), .frame_start(a_fs),
        .frame_count(a_fc)
    );

    // 16 cycles/line (hs low at 10..12), 11 lines/frame (vs low on 7..8), 176 cycles/frame.
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIPE_DELAY(3)
    ) dut_b (
        .vga_clk(clk), .reset_n(rst_b), .DrawX(b_x), .DrawY(b_y), .blank(b_blank),
        .hs(b_hs), .vs(b_vs), .hs_d(b_hs_d), .vs_d(b_vs_d), .frame_start(b_fs),
        .frame_count(b_fc)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    initial begin
        int blank_cnt, blank_min, blank_max, hs_cnt, hs_min, hs_max, seq_err, lag_err;
        int vs_cnt, vs_bad, fs_cnt;
        logic h1, h2, h3, v1, v2, v3;
        bit found;

        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state
        check("rst_x", int'(a_x), 0);
        check("rst_y", int'(a_y), 0);
        check("rst_blank", int'(a_blank), 0);
        check("rst_hs_vs", int'({a_hs, a_vs}), 3);
        check("rst_hsd_vsd", int'({a_hs_d, a_vs_d}), 3);
        check("rst_fc", int'(a_fc), 0);
        check("rst_fs", int'(a_fs), 0);

        // Release: first running cycle is (0,0) visible with frame_start
        rst_a = 1'b1;
        @(negedge clk);
        check("run0_xy", int'({a_x, a_y}), 0);
        check("run0_blank", int'(a_blank), 1);
        check("run0_fs", int'(a_fs), 1);
        check("run0_hs_d", int'(a_hs_d), 1);

        // One full line at default timing, with lag-2 sync alignment
        blank_cnt = 0; blank_min = 9999; blank_max = -1;
        hs_cnt = 0; hs_min = 9999; hs_max = -1;
        seq_err = 0; lag_err = 0;
        h1 = 1'b1; h2 = 1'b1; v1 = 1'b1; v2 = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) @(negedge clk);
            if (int'(a_x) != i || a_y != 10'd0) seq_err++;
            if (a_blank) begin
                blank_cnt++;
                if (int'(a_x) < blank_min) blank_min = int'(a_x);
                if (int'(a_x) > blank_max) blank_max = int'(a_x);
            end
            if (!a_hs) begin
                hs_cnt++;
                if (int'(a_x) < hs_min) hs_min = int'(a_x);
                if (int'(a_x) > hs_max) hs_max = int'(a_x);
            end
            if (i >= 2 && (a_hs_d !== h2 || a_vs_d !== v2)) lag_err++;
            h2 = h1; h1 = a_hs; v2 = v1; v1 = a_vs;
        end
        check("line_seq_err", seq_err, 0);
        check("line_blank_cnt", blank_cnt, 640);
        check("line_blank_min", blank_min, 0);
        check("line_blank_max", blank_max, 639);
        check("line_hs_cnt", hs_cnt, 96);
        check("line_hs_min", hs_min, 656);
        check("line_hs_max", hs_max, 751);
        check("lag2_err", lag_err, 0);
        @(negedge clk);
        check("line_wrap_x", int'(a_x), 0);
        check("line_wrap_y", int'(a_y), 1);

        // Small raster: one frame of blank/vsync/frame_start and lag-3 alignment
        check("b_rst_hs_d", int'(b_hs_d), 1);
        rst_b = 1'b1;
        @(negedge clk);
        check("b_run0_fs", int'(b_fs), 1);
        check("b_run0_vs_d", int'(b_vs_d), 1);
        blank_cnt = 0; vs_cnt = 0; vs_bad = 0; fs_cnt = 0; lag_err = 0;
        h1 = 1'b1; h2 = 1'b1; h3 = 1'b1; v1 = 1'b1; v2 = 1'b1; v3 = 1'b1;
        for (int t = 0; t < 176; t++) begin
            if (t > 0) @(negedge clk);
            if (b_blank) blank_cnt++;
            if (!b_vs) begin
                vs_cnt++;
                if (b_y != 10'd7 && b_y != 10'd8) vs_bad++;
            end
            if (b_fs) fs_cnt++;
            if (b_hs_d !== h3 || b_vs_d !== v3) lag_err++;
            h3 = h2; h2 = h1; h1 = b_hs; v3 = v2; v2 = v1; v1 = b_vs;
            if (t == 175) begin
                check("b_last_x", int'(b_x), 15);
                check("b_last_y", int'(b_y), 10);
                check("b_last_fc", int'(b_fc), 0);
            end
        end
        check("b_blank_cnt", blank_cnt, 48);
        check("b_vs_cnt", vs_cnt, 32);
        check("b_vs_bad", vs_bad, 0);
        check("b_fs_cnt", fs_cnt, 1);
        check("lag3_err", lag_err, 0);
        @(negedge clk);
        check("b_wrap_xy", int'({b_x, b_y}), 0);
        check("b_wrap_fc", int'(b_fc), 1);
        check("b_wrap_fs", int'(b_fs), 1);

        // Mid-frame reset at (5,4) of frame 3
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            @(negedge clk);
            if (b_fc == 8'd3 && b_x == 10'd5 && b_y == 10'd4) found = 1'b1;
        end
        check("mid_found", int'(found), 1);
        rst_b = 1'b0;
        @(negedge clk);
        check("mid_rst_xy", int'({b_x, b_y}), 0);
        check("mid_rst_blank", int'(b_blank), 0);
        check("mid_rst_fc", int'(b_fc), 0);
        check("mid_rst_fs", int'(b_fs), 0);
        rst_b = 1'b1;
        @(negedge clk);
        check("mid_run_xy", int'({b_x, b_y}), 0);
        check("mid_run_blank", int'(b_blank), 1);
        check("mid_run_fs", int'(b_fs), 1);

        // 256 frames: frame_count wraps 255 -> 0, 257 frame_start pulses
        fs_cnt = 1;
        for (int t = 1; t <= 256 * 176; t++) begin
            @(negedge clk);
            if (b_fs) fs_cnt++;
            if (t == 255 * 176) check("wrap_fc_255", int'(b_fc), 255);
            if (t == 256 * 176 - 1) check("wrap_fc_pre", int'(b_fc), 255);
        end
        check("wrap_fc_0", int'(b_fc), 0);
        check("wrap_fs_cnt", fs_cnt, 257);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
